main_mem_ctrl: RTL and testbench

//  Block-granular backing store and controller directly downstream of the 4-way cache data array.

---
 rtl/main_mem_ctrl.sv | 107 ++++++++++
 tb/tb_main_mem_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/main_mem_ctrl.sv
// main_mem_ctrl: block store behind the cache; serves victim write-backs and line fills, writes before reads.
// Define MAIN_MEM_STATS_EN to add saturating rd_cnt/wr_cnt commit counters.
module main_mem_ctrl #(
    parameter int PA_WIDTH  = 32,
    parameter int BLK_WIDTH = 512,
    parameter int OFF_BITS  = 6,
    parameter int MEM_DEPTH = 1024,
    parameter int RD_LAT    = 4,
    parameter int WR_LAT    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PA_WIDTH-1:0]  mem_addr,
    input  logic [PA_WIDTH-1:0]  mem_wb_addr,
    input  logic                 mem_rd_en,
    input  logic                 mem_wr_en,
    input  logic [BLK_WIDTH-1:0] mem_wr_blk,
`ifdef MAIN_MEM_STATS_EN
    output logic [31:0]          rd_cnt,
    output logic [31:0]          wr_cnt,
`endif
    output logic [BLK_WIDTH-1:0] mem_rd_blk,
    output logic                 mem_busy,
    output logic                 mem_done
);
    localparam int IW = $clog2(MEM_DEPTH);
    localparam int CW = $clog2((RD_LAT > WR_LAT ? RD_LAT : WR_LAT) + 1);
    localparam logic [CW-1:0] RD_M1 = CW'(RD_LAT - 1);
    localparam logic [CW-1:0] WR_M1 = CW'(WR_LAT - 1);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic                 rd_q;
    logic [IW-1:0]        rd_idx;
    logic [IW-1:0]        wb_idx;
    logic [BLK_WIDTH-1:0] wr_blk_q;
    logic [BLK_WIDTH-1:0] mem [MEM_DEPTH];
    logic                 wr_commit;
    logic                 addr_unused;

    // Offset and alias bits above the index never select storage.
    assign addr_unused = ^{mem_addr[PA_WIDTH-1:OFF_BITS+IW], mem_addr[OFF_BITS-1:0],
                           mem_wb_addr[PA_WIDTH-1:OFF_BITS+IW], mem_wb_addr[OFF_BITS-1:0]};
    assign wr_commit = (state == WRITE) && (cnt == '0);

    // Array is not reset; reset forces IDLE so an uncommitted write is simply lost.
    always_ff @(posedge clk)
        if (wr_commit) mem[wb_idx] <= wr_blk_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            rd_q       <= 1'b0;
            rd_idx     <= '0;
            wb_idx     <= '0;
            wr_blk_q   <= '0;
            mem_rd_blk <= '0;
            mem_busy   <= 1'b0;
            mem_done   <= 1'b0;
`ifdef MAIN_MEM_STATS_EN
            rd_cnt     <= '0;
            wr_cnt     <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (mem_rd_en || mem_wr_en) begin
                    rd_q     <= mem_rd_en;
                    rd_idx   <= mem_addr[OFF_BITS +: IW];
                    wb_idx   <= mem_wb_addr[OFF_BITS +: IW];
                    wr_blk_q <= mem_wr_blk;
                    mem_busy <= 1'b1;
                    state    <= mem_wr_en ? WRITE : READ;
                    cnt      <= mem_wr_en ? WR_M1 : RD_M1;
                end
                WRITE: if (cnt == '0) begin
                    state    <= rd_q ? READ : DONE;
                    cnt      <= RD_M1;
                    mem_busy <= rd_q;
                    mem_done <= !rd_q;
`ifdef MAIN_MEM_STATS_EN
                    wr_cnt   <= (wr_cnt == '1) ? wr_cnt : wr_cnt + 32'd1;
`endif
                end else begin
                    cnt <= cnt - 1'b1;
                end
                READ: if (cnt == '0) begin
                    mem_rd_blk <= mem[rd_idx];
                    state      <= DONE;
                    mem_busy   <= 1'b0;
                    mem_done   <= 1'b1;
`ifdef MAIN_MEM_STATS_EN
                    rd_cnt     <= (rd_cnt == '1) ? rd_cnt : rd_cnt + 32'd1;
`endif
                end else begin
                    cnt <= cnt - 1'b1;
                end
                default: begin
                    mem_done <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_main_mem_ctrl.sv
// tb_main_mem_ctrl: directed and random requests against a block-array reference model.
module tb_main_mem_ctrl;
    localparam int RD_LAT = 4;
    localparam int WR_LAT = 4;
    localparam int DEPTH  = 1024;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [31:0]  mem_addr = '0;
    logic [31:0]  mem_wb_addr = '0;
    logic         mem_rd_en = 1'b0;
    logic         mem_wr_en = 1'b0;
    logic [511:0] mem_wr_blk = '0;
    logic [511:0] mem_rd_blk;
    logic         mem_busy;
    logic         mem_done;
`ifdef MAIN_MEM_STATS_EN
    logic [31:0]  rd_cnt;
    logic [31:0]  wr_cnt;
`endif

    main_mem_ctrl dut (
        .clk(clk),
        .rst_n(rst_n),
        .mem_addr(mem_addr),
        .mem_wb_addr(mem_wb_addr),
        .mem_rd_en(mem_rd_en),
        .mem_wr_en(mem_wr_en),
        .mem_wr_blk(mem_wr_blk),
`ifdef MAIN_MEM_STATS_EN
        .rd_cnt(rd_cnt),
        .wr_cnt(wr_cnt),
`endif
        .mem_rd_blk(mem_rd_blk),
        .mem_busy(mem_busy),
        .mem_done(mem_done)
    );

    always #5 clk = ~clk;

    int           total = 0;
    int           bad = 0;
    logic [511:0] ref_mem [DEPTH];
    logic [511:0] ref_rd = '0;
    longint       ref_rc = 0;
    longint       ref_wc = 0;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int blk_idx(input logic [31:0] a);
        return int'((a / 64) % DEPTH);
    endfunction

    function automatic logic [511:0] rand_blk();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    task automatic chk_stats();
`ifdef MAIN_MEM_STATS_EN
        chk("rd_cnt", rd_cnt, ref_rc);
        chk("wr_cnt", wr_cnt, ref_wc);
`endif
    endtask

    // One request held for the accept edge; optional poke fires a read while busy.
    task automatic req(input bit rd, input bit wr, input logic [31:0] ra, input logic [31:0] wa,
                       input logic [511:0] blk, input bit poke);
        int  n;
        int  k;
        bit  busy_ok;
        n = (wr ? WR_LAT : 0) + (rd ? RD_LAT : 0);
        @(negedge clk);
        mem_rd_en = rd; mem_wr_en = wr; mem_addr = ra; mem_wb_addr = wa; mem_wr_blk = blk;
        @(posedge clk); #1;
        mem_rd_en = 1'b0; mem_wr_en = 1'b0; mem_wr_blk = ~blk;
        chk("busy_acc", mem_busy, 1);
        k = 0;
        busy_ok = 1'b1;
        while (!mem_done && k < n + 4) begin
            if (poke && k == 1) begin mem_rd_en = 1'b1; mem_addr = 32'h200; end
            if (poke && k == 2) mem_rd_en = 1'b0;
            @(posedge clk); #1;
            k++;
            if (!mem_done && mem_busy !== 1'b1) busy_ok = 1'b0;
        end
        chk("busy_hold", busy_ok, 1);
        chk("latency", k, n);
        chk("busy_done", mem_busy, 0);
        if (wr) begin
            ref_mem[blk_idx(wa)] = blk;
            if (ref_wc < 64'hFFFF_FFFF) ref_wc++;
        end
        if (rd) begin
            ref_rd = ref_mem[blk_idx(ra)];
            if (ref_rc < 64'hFFFF_FFFF) ref_rc++;
        end
        chk("rd_blk", mem_rd_blk, ref_rd);
        chk_stats();
        @(posedge clk); #1;
        chk("done_pulse", mem_done, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic [511:0] b_pre;
        logic [511:0] b_new;
        logic [511:0] b1;
        logic [511:0] b2;
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i] = '0;
            dut.mem[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_blk", mem_rd_blk, 0);
        chk("rst_busy", mem_busy, 0);
        chk("rst_done", mem_done, 0);
        chk_stats();
        @(negedge clk) rst_n = 1'b1;

        req(1, 0, 32'h0000_0040, 32'h0, '0, 0);
        req(0, 1, 32'h0, 32'h80, {64{8'hA5}}, 0);
        req(1, 0, 32'h80, 32'h0, '0, 0);
        chk("read_a5", mem_rd_blk, {64{8'hA5}});
        req(1, 1, 32'h1C0, 32'h1C0, 512'h1234, 0);
        chk("wr_then_rd", mem_rd_blk, 512'h1234);
        req(1, 0, 32'h80, 32'h0, '0, 1);
        req(1, 0, 32'h200, 32'h0, '0, 0);

        b_pre = rand_blk();
        b_new = rand_blk();
        req(0, 1, 32'h0, 32'h40, b_pre, 0);
        req(1, 0, 32'h40, 32'h0, '0, 0);
        @(negedge clk);
        mem_wr_en = 1'b1; mem_wb_addr = 32'h40; mem_wr_blk = b_new;
        @(posedge clk); #1;
        mem_wr_en = 1'b0;
        repeat (WR_LAT - 1) @(posedge clk);
        #1;
        chk("busy_pre_rst", mem_busy, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_rd_blk", mem_rd_blk, 0);
        chk("abort_busy", mem_busy, 0);
        chk("abort_done", mem_done, 0);
        ref_rd = '0; ref_rc = 0; ref_wc = 0;
        chk_stats();
        @(negedge clk) rst_n = 1'b1;
        req(1, 0, 32'h40, 32'h0, '0, 0);
        chk("write_lost", mem_rd_blk, b_pre);

        b1 = rand_blk();
        b2 = rand_blk();
        req(0, 1, 32'h0, 32'h40, b1, 0);
        req(0, 1, 32'h0, 32'h40 + DEPTH * 64, b2, 0);
        req(1, 0, 32'h40, 32'h0, '0, 0);
        chk("alias", mem_rd_blk, b2);

        repeat (40) begin
            bit rd;
            bit wr;
            logic [31:0] ra;
            logic [31:0] wa;
            rd = 1'($urandom);
            wr = rd ? 1'($urandom) : 1'b1;
            ra = ($urandom << 16) | ($urandom_range(0, 7) << 6) | $urandom_range(0, 63);
            wa = ($urandom << 16) | ($urandom_range(0, 7) << 6) | $urandom_range(0, 63);
            req(rd, wr, ra, wa, rand_blk(), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
